// File: rtl/block_mean_table_sched_if.sv
// Bus bundle for block_mean_table_sched: block-mean write stream, two read ports, frame status.
// master drives the stream and read requests; slave is the scheduler.
interface block_mean_table_sched_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              vs;
    logic              mean_vld;
    logic [23:0]       mean_color;
    logic [5:0]        block_v_cnt;
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvld0;
    logic              rvld1;
    logic [23:0]       rdata;
    logic              frame_ready;
    logic              bank_sel;
    logic              frame_done;
    logic              frame_drop;
    logic [15:0]       frame_cnt;
    logic              row_ovf;

    modport master (
        output vs, mean_vld, mean_color, block_v_cnt, req0, req1, addr0, addr1,
        input  gnt0, gnt1, rvld0, rvld1, rdata, frame_ready, bank_sel, frame_done, frame_drop,
               frame_cnt, row_ovf
    );

    modport slave (
        input  vs, mean_vld, mean_color, block_v_cnt, req0, req1, addr0, addr1,
        output gnt0, gnt1, rvld0, rvld1, rdata, frame_ready, bank_sel, frame_done, frame_drop,
               frame_cnt, row_ovf
    );
endinterface

// File: rtl/block_mean_table_sched.sv
// Ping-pong block-mean table with frame commit and a two-port round-robin reader.
// Optional status counters (frame_cnt, row_ovf) are enabled by defining BLK_SCHED_STATUS_EN.
module block_mean_table_sched #(
    parameter int unsigned BLK_H  = 16,
    parameter int unsigned BLK_V  = 9,
    parameter int unsigned ADDR_W = 10
) (
    input logic                   clk,
    input logic                   rstn,
    block_mean_table_sched_if.slave bus
);
    localparam int unsigned TOTAL = BLK_H * BLK_V;
    localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned COL_W = 7;
    localparam logic [ADDR_W:0] TOTAL_CNT = (ADDR_W + 1)'(TOTAL);

    typedef enum logic {StWaitVs, StFill} state_e;

    state_e            state_q, state_d;
    logic              vs_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d, wr_cnt_inc;
    logic              bank_sel_q, frame_ready_q, frame_done_q, frame_drop_q;
    logic              prio_q, prio_d;
    logic              rvld0_q, rvld1_q;
    logic [23:0]       rdata_q, rdata_d, rd_data;
    logic              vs_rise, in_range, wr_en, commit, discard;
    logic              gnt0, gnt1, rd_ok;
    logic [IDX_W-1:0]  wr_addr, rd_idx;
    logic [ADDR_W-1:0] rd_addr;

    logic [23:0] mem [0:1][0:TOTAL-1];

    assign vs_rise  = bus.vs & ~vs_q;
    assign in_range = (32'(col_q) < BLK_H) && (32'(bus.block_v_cnt) < BLK_V);
    assign wr_en    = (state_q == StFill) && bus.mean_vld && in_range;
    assign wr_addr  = IDX_W'(BLK_H * 32'(bus.block_v_cnt) + 32'(col_q));

    // A beat arriving with the vs rise is counted before the completeness check.
    assign wr_cnt_inc = (wr_en && wr_cnt_q != TOTAL_CNT) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    assign commit     = (state_q == StFill) && vs_rise && (wr_cnt_inc == TOTAL_CNT);
    assign discard    = (state_q == StFill) && vs_rise && !commit;

    always_comb begin
        state_d  = state_q;
        col_d    = '0;
        wr_cnt_d = '0;
        unique case (state_q)
            StWaitVs: begin
                if (vs_rise) state_d = StFill;
            end
            StFill: begin
                if (!vs_rise) begin
                    wr_cnt_d = wr_cnt_inc;
                    if (bus.mean_vld) col_d = (col_q == '1) ? col_q : col_q + 1'b1;
                end
            end
            default: state_d = StWaitVs;
        endcase
    end

    // Round-robin: prio_q names the port that wins a tie.
    assign gnt0    = bus.req0 & (~bus.req1 | ~prio_q);
    assign gnt1    = bus.req1 & (~bus.req0 | prio_q);
    assign prio_d  = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : prio_q);
    assign rd_addr = gnt1 ? bus.addr1 : bus.addr0;
    assign rd_ok   = 32'(rd_addr) < TOTAL;
    assign rd_idx  = IDX_W'(rd_addr);
    assign rd_data = (frame_ready_q && rd_ok) ? mem[bank_sel_q][rd_idx] : '0;
    assign rdata_d = (gnt0 | gnt1) ? rd_data : rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[~bank_sel_q][wr_addr] <= bus.mean_color;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StWaitVs;
            vs_q          <= 1'b0;
            col_q         <= '0;
            wr_cnt_q      <= '0;
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_drop_q  <= 1'b0;
            prio_q        <= 1'b0;
            rvld0_q       <= 1'b0;
            rvld1_q       <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= bus.vs;
            col_q         <= col_d;
            wr_cnt_q      <= wr_cnt_d;
            bank_sel_q    <= bank_sel_q ^ commit;
            frame_ready_q <= frame_ready_q | commit;
            frame_done_q  <= commit;
            frame_drop_q  <= discard;
            prio_q        <= prio_d;
            rvld0_q       <= gnt0;
            rvld1_q       <= gnt1;
            rdata_q       <= rdata_d;
        end
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.rvld0       = rvld0_q;
    assign bus.rvld1       = rvld1_q;
    assign bus.rdata       = rdata_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.bank_sel    = bank_sel_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_drop  = frame_drop_q;

`ifdef BLK_SCHED_STATUS_EN
    logic [15:0] frame_cnt_q;
    logic        row_ovf_q;
    logic        beat_drop;

    assign beat_drop = (state_q == StFill) && bus.mean_vld && !in_range;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            row_ovf_q   <= 1'b0;
        end else begin
            if (commit) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (commit) row_ovf_q <= 1'b0;
            else if (beat_drop) row_ovf_q <= 1'b1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.row_ovf   = row_ovf_q;
`else
    assign bus.frame_cnt = '0;
    assign bus.row_ovf   = 1'b0;
`endif
endmodule
